// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//   Extends a raw IN_W-bit immediate to OUT_W bits in one of four modes and
//   queues the extended result in a small DEPTH-entry FIFO. Extension happens
//   on the way in, so the buffer holds finished OUT_W results.
//
//   Handshake: a transfer happens on any rising edge where valid and ready are
//   both high on that side. Upstream push is valid_i && ready_o, downstream pop
//   is valid_o && ready_i. ready_o never looks at ready_i, and valid_o/data_o
//   come from registered state only, so no input reaches data_o combinationally.
//
// Ports
//   clk_i    : clock, all state on the rising edge
//   rst_i    : synchronous active-high reset (clears control state only)
//   valid_i  : upstream offers data_i/mode_i
//   ready_o  : block can accept an entry (not full and not in reset)
//   data_i   : raw immediate, IN_W bits
//   mode_i   : 00 sign, 01 zero, 10 upper, 11 sign then shift left by 2
//   valid_o  : data_o holds the head result
//   ready_i  : downstream consumes data_o
//   data_o   : head result, zero when empty
//   count_o  : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [IN_W-1:0]          data_i,
  input  logic [1:0]               mode_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [OUT_W-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EXT_W = OUT_W - IN_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("imm_extend_pipe: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] ext_value;
  logic [OUT_W-1:0] sign_value;
  logic             push;
  logic             pop;

  // Sign extension is shared by modes 00 and 11.
  assign sign_value = {{EXT_W{data_i[IN_W-1]}}, data_i};

  always_comb begin
    ext_value = '0;
    case (mode_i)
      2'b00:   ext_value = sign_value;
      2'b01:   ext_value = {{EXT_W{1'b0}}, data_i};
      2'b10:   ext_value = {data_i, {EXT_W{1'b0}}};
      default: ext_value = sign_value << 2;
    endcase
  end

  // ready_o drops during reset so upstream never sees a push that gets lost.
  assign ready_o = (count < FULL_CNT) && !rst_i;
  assign valid_o = (count != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; valid_o gates everything that reads it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= ext_value;
    end
  end

  assign data_o  = valid_o ? mem[rd_ptr] : '0;
  assign count_o = count;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
//   Directed bench for imm_extend_pipe at IN_W=16, OUT_W=32, DEPTH=2.
//   Inputs change 1 ns after a rising edge; outputs are checked in the same
//   window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_i;
  logic [1:0]  mode_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [1:0]  count_o;

  int vectors;
  int errors;

  logic [31:0] exp_q[$];

  imm_extend_pipe #(
    .IN_W  (16),
    .OUT_W (32),
    .DEPTH (2)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .mode_i  (mode_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m,
                       input logic r);
    valid_i = v;
    data_i  = d;
    mode_i  = m;
    ready_i = r;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    step();
    step();
    vectors++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    vectors++;
    if (data_o !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000000", data_o);
    end
    vectors++;
    if (count_o !== 2'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count_o);
    end
    vectors++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b want 0", ready_o);
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready_release: got %b want 1", ready_o);
    end
  endtask

  task automatic test_sign();
    drive(1'b1, 16'h8001, 2'b00, 1'b1);
    step();
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 32'hFFFF8001) begin
      errors++; $display("FAIL sign_neg: got v=%b %h want v=1 ffff8001", valid_o, data_o);
    end
    drive(1'b1, 16'h7FFF, 2'b00, 1'b1);
    step();
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 32'h00007FFF) begin
      errors++; $display("FAIL sign_pos: got v=%b %h want v=1 00007fff", valid_o, data_o);
    end
    vectors++;
    if (count_o !== 2'd1) begin
      errors++; $display("FAIL sign_count: got %0d want 1", count_o);
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    step();
    vectors++;
    if (valid_o !== 1'b0 || data_o !== 32'h0 || count_o !== 2'd0) begin
      errors++; $display("FAIL sign_drain: got v=%b %h c=%0d want v=0 0 c=0",
                         valid_o, data_o, count_o);
    end
  endtask

  task automatic test_modes();
    logic [15:0] din [4];
    logic [1:0]  mdin [4];
    logic [31:0] want [4];
    din[0] = 16'h8001; mdin[0] = 2'b01; want[0] = 32'h00008001;
    din[1] = 16'h1234; mdin[1] = 2'b10; want[1] = 32'h12340000;
    din[2] = 16'hFFFF; mdin[2] = 2'b11; want[2] = 32'hFFFFFFFC;
    din[3] = 16'h4000; mdin[3] = 2'b11; want[3] = 32'h00010000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, din[i], mdin[i], 1'b1);
      step();
      vectors++;
      if (valid_o !== 1'b1 || data_o !== want[i]) begin
        errors++; $display("FAIL mode_%0d: got v=%b %h want v=1 %h", i, valid_o, data_o, want[i]);
      end
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    step();
    vectors++;
    if (count_o !== 2'd0) begin
      errors++; $display("FAIL modes_drain: got %0d want 0", count_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h0011, 2'b01, 1'b0);
    step();
    vectors++;
    if (count_o !== 2'd1 || ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_one: got c=%0d r=%b want c=1 r=1", count_o, ready_o);
    end
    drive(1'b1, 16'h0022, 2'b01, 1'b0);
    step();
    drive(1'b1, 16'h0033, 2'b01, 1'b0);
    #1;
    vectors++;
    if (count_o !== 2'd2 || ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_full: got c=%0d r=%b want c=2 r=0", count_o, ready_o);
    end
    step();
    vectors++;
    if (count_o !== 2'd2 || data_o !== 32'h00000011 || valid_o !== 1'b1) begin
      errors++; $display("FAIL b2b_hold: got c=%0d v=%b %h want c=2 v=1 00000011",
                         count_o, valid_o, data_o);
    end
    ready_i = 1'b1;
    step();
    vectors++;
    if (count_o !== 2'd1 || data_o !== 32'h00000022) begin
      errors++; $display("FAIL b2b_pop_a: got c=%0d %h want c=1 00000022", count_o, data_o);
    end
    step();
    vectors++;
    if (count_o !== 2'd1 || data_o !== 32'h00000033) begin
      errors++; $display("FAIL b2b_pop_b: got c=%0d %h want c=1 00000033", count_o, data_o);
    end
    valid_i = 1'b0;
    step();
    vectors++;
    if (count_o !== 2'd0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_empty: got c=%0d v=%b want c=0 v=0", count_o, valid_o);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 16'h0044, 2'b01, 1'b0);
    step();
    drive(1'b1, 16'h0055, 2'b01, 1'b1);
    #1;
    vectors++;
    if (data_o !== 32'h00000044) begin
      errors++; $display("FAIL simul_old: got %h want 00000044", data_o);
    end
    step();
    vectors++;
    if (count_o !== 2'd1 || data_o !== 32'h00000055) begin
      errors++; $display("FAIL simul_new: got c=%0d %h want c=1 00000055", count_o, data_o);
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    step();
    vectors++;
    if (count_o !== 2'd0) begin
      errors++; $display("FAIL simul_drain: got %0d want 0", count_o);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h0066, 2'b01, 1'b0);
    step();
    step();
    vectors++;
    if (count_o !== 2'd2) begin
      errors++; $display("FAIL rmid_fill: got %0d want 2", count_o);
    end
    rst_i = 1'b1;
    drive(1'b1, 16'h0077, 2'b01, 1'b1);
    #1;
    step();
    vectors++;
    if (valid_o !== 1'b0 || data_o !== 32'h0 || count_o !== 2'd0) begin
      errors++; $display("FAIL rmid_clear: got v=%b %h c=%0d want v=0 0 c=0",
                         valid_o, data_o, count_o);
    end
    rst_i = 1'b0;
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    #1;
    vectors++;
    if (ready_o !== 1'b1 || count_o !== 2'd0) begin
      errors++; $display("FAIL rmid_release: got r=%b c=%0d want r=1 c=0", ready_o, count_o);
    end
    drive(1'b1, 16'h8000, 2'b00, 1'b0);
    step();
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 32'hFFFF8000 || count_o !== 2'd1) begin
      errors++; $display("FAIL rmid_push: got v=%b %h c=%0d want v=1 ffff8000 c=1",
                         valid_o, data_o, count_o);
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    step();
    vectors++;
    if (count_o !== 2'd0) begin
      errors++; $display("FAIL rmid_drain: got %0d want 0", count_o);
    end
  endtask

  // Nine zero-extended entries 0xA000..0xA008 with ready_i toggling each
  // cycle; the bench tracks occupancy itself to predict ready_o/valid_o.
  task automatic test_wrap();
    int sent;
    int got;
    int cnt;
    logic do_push;
    logic do_pop;
    logic [31:0] want;
    sent = 0;
    got  = 0;
    cnt  = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && got < 9; cyc++) begin
      drive(sent < 9, 16'hA000 + 16'(sent), 2'b01, cyc[0]);
      #1;
      do_push = valid_i && (cnt < 2);
      do_pop  = (cnt > 0) && ready_i;
      vectors++;
      if (ready_o !== (cnt < 2) || valid_o !== (cnt > 0) || count_o !== 2'(cnt)) begin
        errors++; $display("FAIL wrap_ctrl cyc %0d: got r=%b v=%b c=%0d want r=%b v=%b c=%0d",
                           cyc, ready_o, valid_o, count_o, cnt < 2, cnt > 0, cnt);
      end
      if (do_pop) begin
        want = exp_q.pop_front();
        vectors++;
        if (data_o !== want) begin
          errors++; $display("FAIL wrap_data %0d: got %h want %h", got, data_o, want);
        end
        got++;
      end
      if (do_push) begin
        exp_q.push_back(32'h0000A000 + 32'(sent));
        sent++;
      end
      cnt = cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      step();
    end
    vectors++;
    if (got != 9 || sent != 9) begin
      errors++; $display("FAIL wrap_total: got %0d out %0d in want 9 9", got, sent);
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    #1;
    vectors++;
    if (count_o !== 2'd0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL wrap_empty: got c=%0d v=%b want c=0 v=0", count_o, valid_o);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_i   = 1'b1;
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    test_reset();
    test_sign();
    test_modes();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16: width of the raw immediate field.
REQ-002 Parameter OUT_W, default 32: width of the extended result; legal only when OUT_W >= IN_W+2.
REQ-003 Parameter DEPTH, default 2: output buffer entries; power of two, >= 2.
REQ-004 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_i  input  1  reset, synchronous, active-high.
REQ-006 Port valid_i  input  1  upstream offers data_i/mode_i this cycle.
REQ-007 Port ready_o  output  1  block can accept an entry this cycle.
REQ-008 Port data_i  input  IN_W  raw immediate.
REQ-009 Port mode_i  input  2  extension mode, sampled with data_i.
REQ-010 Port valid_o  output  1  data_o holds a valid result.
REQ-011 Port ready_i  input  1  downstream consumes data_o this cycle.
REQ-012 Port data_o  output  OUT_W  extended result at buffer head.
REQ-013 Port count_o  output  clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-014 Push occurs when valid_i && ready_o; pop occurs when valid_o && ready_i.
REQ-015 Mode 00 SIGN: data_i[IN_W-1] replicated into bits OUT_W-1:IN_W, data_i in IN_W-1:0.
REQ-016 Mode 01 ZERO: bits OUT_W-1:IN_W zero, data_i in IN_W-1:0.
REQ-017 Mode 10 UPPER: data_i in OUT_W-1:OUT_W-IN_W, remaining low bits zero.
REQ-018 Mode 11 SIGN_SHL2: SIGN result shifted left by 2, low 2 bits zero, truncated to OUT_W.
REQ-019 Extension computed at push; buffer stores the OUT_W result, not raw data/mode.
REQ-020 Latency: pushed entry visible on data_o/valid_o the cycle after the push edge when buffer was empty; no combinational input-to-output path.
REQ-021 ready_o = (count_o < DEPTH) && !rst_i; never depends on ready_i.
REQ-022 valid_o = (count_o != 0); data_o = head entry when valid_o, all zeros otherwise.
REQ-023 Results leave in strict push order (FIFO).
REQ-024 Push only: count +1; pop only: count -1; push and pop same cycle: count unchanged, both pointers advance.
REQ-025 Full (count = DEPTH): ready_o low, valid_i ignored, data_i/mode_i may change freely.
REQ-026 Empty: ready_i ignored, no pointer movement.
REQ-027 Read and write pointers wrap modulo DEPTH without skipping or duplicating entries.
REQ-028 data_o and valid_o stable while valid_o && !ready_i.

Reset
REQ-029 rst_i high at a clock edge: count_o=0, both pointers=0, valid_o=0, data_o=0 after that edge.
REQ-030 While rst_i high, ready_o=0 and any push or pop that cycle is discarded.
REQ-031 Reset mid-operation drops all buffered entries; first cycle after rst_i low, ready_o=1, count_o=0.
REQ-032 Buffer storage contents need no reset; only control state does.

Verification (IN_W=16, OUT_W=32, DEPTH=2)
REQ-033 Push 0x8001 mode 00, then 0x7FFF mode 00, ready_i=1 -> data_o 0xFFFF8001 then 0x00007FFF, each one cycle after push.
REQ-034 Push 0x8001 mode 01, 0x1234 mode 10, 0xFFFF mode 11, 0x4000 mode 11 -> 0x00008001, 0x12340000, 0xFFFFFFFC, 0x00010000.
REQ-035 ready_i=0, offer A,B,C back-to-back -> count_o=2, ready_o=0 while C held; raise ready_i -> A, B, C emerge in order, count_o returns to 0.
REQ-036 count_o=1, push and pop same cycle -> count_o stays 1, popped entry is older one, new entry next.
REQ-037 count_o=2, assert rst_i one cycle -> next cycle valid_o=0, data_o=0, count_o=0; after release ready_o=1, next push emerges normally.
REQ-038 Stream 9 entries with ready_i toggling every cycle -> all 9 emerge in order, no loss or duplication across pointer wrap.
